wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back end of the MEM/WB pipeline register: consumes the registered write-enable, destination index and 64-bit result, and commits them into the processor's scalar and vector register files. It also provides the decode stage with two combinational read ports per file. It sits after the MEM/WB register and before decode, closing the pipeline loop.

## Interface

Parameters:
- NREG, 16: registers per file; index width is clog2(NREG) = 4.
- SW, 32: scalar register width.
- VW, 64: vector register width; equals the write-back data width.

Ports:
- clk  input  1  clock; all writes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wEnRegWB_In  input  2  write enables from MEM/WB; bit0 = scalar file, bit1 = vector file.
- rdWB_In  input  4  destination register index.
- writeDataWB_In  input  64  result to commit.
- sAddrA, sAddrB  input  4 each  scalar read addresses.
- vAddrA, vAddrB  input  4 each  vector read addresses.
- sDataA, sDataB  output  32 each  scalar read data.
- vDataA, vDataB  output  64 each  vector read data.
- wbValid  output  1  registered; 1 for one cycle after any commit.
- wbCount  output  16  registered count of committed write-back operations.

## Operation

- Scalar write: wEnRegWB_In[0]=1 at a clock edge stores writeDataWB_In[31:0] into scalar[rdWB_In]. Scalar register 0 is hardwired to zero: writes to it are dropped and reads return 0.
- Vector write: wEnRegWB_In[1]=1 stores all 64 bits into vector[rdWB_In]. All 16 vector registers are writable.
- wEnRegWB_In=2'b11: both writes happen in the same edge to the same index. Scalar rd=0 is still dropped; the vector write proceeds.
- wEnRegWB_In=2'b00: no state change except wbValid going to 0.
- Reads are combinational from the array (subject to the Configuration section). Address A and B may be equal; both ports then return the same value.
- wbCount increments by 1 on each edge where wEnRegWB_In != 0. A dual write counts once. A dropped scalar write to r0 with no vector write still counts.
- wbCount wraps from 0xFFFF to 0x0000.
- wbValid <= |wEnRegWB_In on every edge.

## Timing

- Reset (asynchronous, immediate):
  - Every scalar and vector register is cleared to 0.
  - wbValid=0, wbCount=0.
  - Read outputs therefore show 0 while rst is high.
- rst asserted in the same cycle as a write: reset wins and the write is lost.
- Write latency: data written at edge N is visible on the read ports from edge N onward, i.e. to reads evaluated after the edge.
- wbValid and wbCount reflect edge N immediately after edge N.
- No handshake: the upstream MEM/WB register presents one write per cycle, and this block never stalls.

## Configuration

Macro WB_BYPASS_EN controls read-during-write forwarding.
- Defined:
  - A scalar read whose address equals rdWB_In, while wEnRegWB_In[0]=1 and rdWB_In!=0, returns writeDataWB_In[31:0] in the same cycle, before the edge.
  - A vector read with matching address and wEnRegWB_In[1]=1 returns writeDataWB_In.
  - Forwarding is purely combinational, so decode sees the result without a stall.
- Undefined: reads return only the stored array contents, and the new value appears after the edge. Hazard handling is then done elsewhere.

## Structure

- Shared package pipeline_pkg holds:
  - NREG, SW, VW and the register index width.
  - Bit positions WEN_SCALAR=0 and WEN_VECTOR=1.
- Sub-module regbank (parameters WIDTH, ZERO_REG0) is instantiated twice:
  - scalar: WIDTH=SW, ZERO_REG0=1.
  - vector: WIDTH=VW, ZERO_REG0=0.
- regbank contains the array, the asynchronous reset, one write port, two read ports and the optional bypass.
- The top level holds the enable decode, wbValid and wbCount.

## Test plan

- Reset: pulse rst mid-simulation after writes -> all sData*/vData* read 0, wbCount=0, wbValid=0, with no clock edge needed.
- Vector write: wEn=2'b10, rd=5, data=0x0123456789ABCDEF -> after edge vDataA (addr 5)=0x0123456789ABCDEF, scalar[5] unchanged, wbValid=1, wbCount=1.
- Dual write / r0: wEn=2'b11, rd=0, data=0xFFFFFFFF_AAAAAAAA -> sDataA (addr 0)=0 and vector[0]=0xFFFFFFFFAAAAAAAA. Then wEn=2'b01, rd=3, data low word=0xDEADBEEF -> sDataB (addr 3)=0xDEADBEEF, wbCount=2.
- Bypass: wEn=2'b10, rd=7, data=0x55, vAddrA=7 before the edge:
  - WB_BYPASS_EN defined -> vDataA=0x55 pre-edge.
  - WB_BYPASS_EN undefined -> old value pre-edge, 0x55 post-edge.
- Counter wrap: 65536 consecutive writes -> wbCount returns to 0x0000; a following idle cycle gives wbValid=0 with wbCount held.
- Reset mid-write: rst rises while wEn=2'b10, rd=2, data=0x99 -> vector[2]=0 after rst deasserts.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register file geometry and write-enable bit positions.
package pipeline_pkg;

   localparam int unsigned NREG = 16;
   localparam int unsigned SW   = 32;
   localparam int unsigned VW   = 64;
   localparam int unsigned IDXW = $clog2(NREG);

   localparam int unsigned WEN_SCALAR = 0;
   localparam int unsigned WEN_VECTOR = 1;

endpackage

// File: rtl/regbank.sv
// regbank: NREG x WIDTH register array with one synchronous write port and two
// combinational read ports. Asynchronous active-high reset clears every entry.
// Optional read-during-write forwarding when WB_BYPASS_EN is defined.
// Parameters: WIDTH (data width), ZERO_REG0 (1 = entry 0 hardwired to zero).
// Ports:
//   clk, rst          clock, async active-high reset
//   wen, waddr, wdata write port
//   addr_a, addr_b    read addresses
//   rdata_a, rdata_b  combinational read data
module regbank
   import pipeline_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          ZERO_REG0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic [IDXW-1:0]   waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [IDXW-1:0]   addr_a,
   input  logic [IDXW-1:0]   addr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b
);

   logic [WIDTH-1:0] mem [NREG];
   logic             wr_ok;

   // A write to entry 0 of a zero-hardwired bank is dropped here and in forwarding.
   assign wr_ok = wen && !(ZERO_REG0 && (waddr == '0));

   // Storage array with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports; entry 0 masked for zero banks, forced to 0 during reset.
   always_comb begin
      rdata_a = mem[addr_a];
      rdata_b = mem[addr_b];
`ifdef WB_BYPASS_EN
      if (wr_ok && (addr_a == waddr)) rdata_a = wdata;
      if (wr_ok && (addr_b == waddr)) rdata_b = wdata;
`endif
      if (ZERO_REG0 && (addr_a == '0)) rdata_a = '0;
      if (ZERO_REG0 && (addr_b == '0)) rdata_b = '0;
      if (rst) begin
         rdata_a = '0;
         rdata_b = '0;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage. Commits MEM/WB results into the scalar (r0 = 0)
// and vector register files and serves two read ports per file to decode.
// Optional macro WB_BYPASS_EN enables same-cycle read-during-write forwarding.
// Ports:
//   clk, rst                         clock, async active-high reset
//   wEnRegWB_In[1:0]                 bit0 scalar write, bit1 vector write
//   rdWB_In, writeDataWB_In          destination index and 64-bit result
//   sAddrA/B -> sDataA/B             scalar reads (32-bit)
//   vAddrA/B -> vDataA/B             vector reads (64-bit)
//   wbValid                          registered, 1 for a cycle after any commit
//   wbCount                          registered 16-bit wrapping commit count
module wb_regfile
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      wEnRegWB_In,
   input  logic [3:0]      rdWB_In,
   input  logic [63:0]     writeDataWB_In,
   input  logic [3:0]      sAddrA,
   input  logic [3:0]      sAddrB,
   input  logic [3:0]      vAddrA,
   input  logic [3:0]      vAddrB,
   output logic [31:0]     sDataA,
   output logic [31:0]     sDataB,
   output logic [63:0]     vDataA,
   output logic [63:0]     vDataB,
   output logic            wbValid,
   output logic [15:0]     wbCount
);

   logic s_wen;
   logic v_wen;
   logic any_wen;

   // Enable decode; a dropped r0 scalar write still counts as a commit.
   assign s_wen   = wEnRegWB_In[WEN_SCALAR];
   assign v_wen   = wEnRegWB_In[WEN_VECTOR];
   assign any_wen = s_wen | v_wen;

   regbank #(
      .WIDTH     (SW),
      .ZERO_REG0 (1'b1)
   ) u_scalar (
      .clk     (clk),
      .rst     (rst),
      .wen     (s_wen),
      .waddr   (rdWB_In),
      .wdata   (writeDataWB_In[SW-1:0]),
      .addr_a  (sAddrA),
      .addr_b  (sAddrB),
      .rdata_a (sDataA),
      .rdata_b (sDataB)
   );

   regbank #(
      .WIDTH     (VW),
      .ZERO_REG0 (1'b0)
   ) u_vector (
      .clk     (clk),
      .rst     (rst),
      .wen     (v_wen),
      .waddr   (rdWB_In),
      .wdata   (writeDataWB_In),
      .addr_a  (vAddrA),
      .addr_b  (vAddrB),
      .rdata_a (vDataA),
      .rdata_b (vDataB)
   );

   // Commit status: valid pulse and wrapping commit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbValid <= 1'b0;
         wbCount <= '0;
      end else begin
         wbValid <= any_wen;
         if (any_wen) wbCount <= wbCount + 16'(1);
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [1:0]  wEnRegWB_In;
   logic [3:0]  rdWB_In;
   logic [63:0] writeDataWB_In;
   logic [3:0]  sAddrA, sAddrB, vAddrA, vAddrB;
   logic [31:0] sDataA, sDataB;
   logic [63:0] vDataA, vDataB;
   logic        wbValid;
   logic [15:0] wbCount;

   int checks = 0;
   int errors = 0;

   wb_regfile dut (
      .clk            (clk),
      .rst            (rst),
      .wEnRegWB_In    (wEnRegWB_In),
      .rdWB_In        (rdWB_In),
      .writeDataWB_In (writeDataWB_In),
      .sAddrA         (sAddrA),
      .sAddrB         (sAddrB),
      .vAddrA         (vAddrA),
      .vAddrB         (vAddrB),
      .sDataA         (sDataA),
      .sDataB         (sDataB),
      .vDataA         (vDataA),
      .vDataB         (vDataB),
      .wbValid        (wbValid),
      .wbCount        (wbCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One write committed at the next rising edge, enables dropped right after it.
   task automatic do_write(input logic [1:0] wen, input logic [3:0] rd, input logic [63:0] data);
      @(negedge clk);
      wEnRegWB_In    = wen;
      rdWB_In        = rd;
      writeDataWB_In = data;
      @(posedge clk);
      #1;
      wEnRegWB_In = 2'b00;
   endtask

   initial begin
      rst = 1'b1;
      wEnRegWB_In = 2'b00;
      rdWB_In = 4'd0;
      writeDataWB_In = 64'd0;
      sAddrA = 4'd0; sAddrB = 4'd0; vAddrA = 4'd0; vAddrB = 4'd0;
      #2;
      check("reset_valid", 64'(wbValid), 64'd0);
      check("reset_count", 64'(wbCount), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Vector write to r5
      do_write(2'b10, 4'd5, 64'h0123456789ABCDEF);
      vAddrA = 4'd5; sAddrA = 4'd5;
      #1;
      check("vec_w5", vDataA, 64'h0123456789ABCDEF);
      check("vec_w5_scalar_untouched", 64'(sDataA), 64'd0);
      check("vec_w5_valid", 64'(wbValid), 64'd1);
      check("vec_w5_count", 64'(wbCount), 64'd1);

      // Async reset pulse clears everything without a clock edge
      rst = 1'b1;
      #1;
      check("rst_pulse_v5", vDataA, 64'd0);
      check("rst_pulse_count", 64'(wbCount), 64'd0);
      check("rst_pulse_valid", 64'(wbValid), 64'd0);
      rst = 1'b0;

      // Dual write to r0: scalar dropped, vector kept
      do_write(2'b11, 4'd0, 64'hFFFFFFFF_AAAAAAAA);
      sAddrA = 4'd0; vAddrB = 4'd0;
      #1;
      check("dual_r0_scalar", 64'(sDataA), 64'd0);
      check("dual_r0_vector", vDataB, 64'hFFFFFFFF_AAAAAAAA);
      check("dual_r0_count", 64'(wbCount), 64'd1);

      // Scalar write to r3, only low word stored; A==B read
      do_write(2'b01, 4'd3, 64'h12345678_DEADBEEF);
      sAddrA = 4'd3; sAddrB = 4'd3; vAddrA = 4'd3;
      #1;
      check("scalar_r3_b", 64'(sDataB), 64'h00000000_DEADBEEF);
      check("scalar_r3_a_eq_b", 64'(sDataA), 64'h00000000_DEADBEEF);
      check("scalar_r3_vector_untouched", vDataA, 64'd0);
      check("scalar_r3_count", 64'(wbCount), 64'd2);

      // Idle edge: valid drops, count holds
      @(posedge clk);
      #1;
      check("idle_valid", 64'(wbValid), 64'd0);
      check("idle_count", 64'(wbCount), 64'd2);

      // Read-during-write on vector r7 and scalar r9
      @(negedge clk);
      wEnRegWB_In = 2'b10; rdWB_In = 4'd7; writeDataWB_In = 64'h55;
      vAddrA = 4'd7;
      #1;
`ifdef WB_BYPASS_EN
      check("bypass_vec_pre", vDataA, 64'h55);
`else
      check("bypass_vec_pre", vDataA, 64'd0);
`endif
      @(posedge clk);
      #1;
      wEnRegWB_In = 2'b00;
      #1;
      check("bypass_vec_post", vDataA, 64'h55);

      @(negedge clk);
      wEnRegWB_In = 2'b01; rdWB_In = 4'd9; writeDataWB_In = 64'hAAAA_0000_0000_1234;
      sAddrB = 4'd9;
      #1;
`ifdef WB_BYPASS_EN
      check("bypass_scl_pre", 64'(sDataB), 64'h1234);
`else
      check("bypass_scl_pre", 64'(sDataB), 64'd0);
`endif
      @(posedge clk);
      #1;
      wEnRegWB_In = 2'b00;
      #1;
      check("bypass_scl_post", 64'(sDataB), 64'h1234);

      // Scalar r0 is never forwarded
      @(negedge clk);
      wEnRegWB_In = 2'b01; rdWB_In = 4'd0; writeDataWB_In = 64'h77;
      sAddrA = 4'd0;
      #1;
      check("bypass_r0_pre", 64'(sDataA), 64'd0);
      @(posedge clk);
      #1;
      wEnRegWB_In = 2'b00;
      check("r0_drop_count", 64'(wbCount), 64'd5);

      // Reset while a vector write is presented: write lost
      @(negedge clk);
      wEnRegWB_In = 2'b10; rdWB_In = 4'd2; writeDataWB_In = 64'h99;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      wEnRegWB_In = 2'b00;
      vAddrA = 4'd2; vAddrB = 4'd7;
      #1;
      check("rst_midwrite_v2", vDataA, 64'd0);
      check("rst_midwrite_v7", vDataB, 64'd0);
      check("rst_midwrite_count", 64'(wbCount), 64'd0);

      // Counter wrap over 65536 consecutive commits
      @(negedge clk);
      wEnRegWB_In = 2'b01; rdWB_In = 4'd1; writeDataWB_In = 64'h1;
      repeat (65535) @(posedge clk);
      #1;
      check("wrap_ffff", 64'(wbCount), 64'hFFFF);
      @(posedge clk);
      #1;
      check("wrap_zero", 64'(wbCount), 64'h0000);
      check("wrap_valid", 64'(wbValid), 64'd1);
      wEnRegWB_In = 2'b00;
      @(posedge clk);
      #1;
      check("wrap_idle_valid", 64'(wbValid), 64'd0);
      check("wrap_idle_count", 64'(wbCount), 64'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
